hsv_to_rgb_pipe: RTL and testbench

Pipelined HSV-to-RGB converter: the inverse path of the RGB-to-HSV hue unit in the pixel pipeline. It accepts one 8-bit-per-channel HSV pixel per cycle, with hue in integer degrees, and returns the corresponding 8-bit RGB pixel. Flow control is valid/ready, with a fixed latency of 4 cycles. It sits after the colour-adjust stage, which operates in HSV space, and before the video output formatter.

---
 rtl/hsv_pkg.sv | 40 ++++
 rtl/hsv_div255.sv | 12 +
 rtl/hsv_to_rgb_pipe.sv | 140 ++++++++++++++
 tb/tb_hsv_to_rgb_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared HSV colour-space definitions for the pixel pipeline (RGB<->HSV units).
package hsv_pkg;

    localparam int HUE_DEG_MAX = 360;
    localparam int SECTOR_DEG  = 60;

    typedef logic [7:0] chan_t;

    typedef enum logic [2:0] {
        SEC_0 = 3'd0,
        SEC_1 = 3'd1,
        SEC_2 = 3'd2,
        SEC_3 = 3'd3,
        SEC_4 = 3'd4,
        SEC_5 = 3'd5
    } sector_t;

    // Comparator chain instead of a divider; h is expected already wrapped to 0..359.
    function automatic sector_t hue_sector(input logic [8:0] h);
        if (h < 9'(SECTOR_DEG))          return SEC_0;
        else if (h < 9'(2 * SECTOR_DEG)) return SEC_1;
        else if (h < 9'(3 * SECTOR_DEG)) return SEC_2;
        else if (h < 9'(4 * SECTOR_DEG)) return SEC_3;
        else if (h < 9'(5 * SECTOR_DEG)) return SEC_4;
        else                             return SEC_5;
    endfunction

    function automatic logic [8:0] sector_base(input sector_t sec);
        case (sec)
            SEC_0:   return 9'd0;
            SEC_1:   return 9'(SECTOR_DEG);
            SEC_2:   return 9'(2 * SECTOR_DEG);
            SEC_3:   return 9'(3 * SECTOR_DEG);
            SEC_4:   return 9'(4 * SECTOR_DEG);
            SEC_5:   return 9'(5 * SECTOR_DEG);
            default: return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/hsv_div255.sv
// Combinational rounded divide-by-255; exact for x <= 65025, so the result always fits 8 bits.
module hsv_div255 (
    input  logic [15:0] x,
    output logic [7:0]  y
);

    logic [16:0] sum1;

    assign sum1 = {1'b0, x} + 17'd128;
    assign y    = 8'((sum1 + (sum1 >> 8)) >> 8);

endmodule

// File: rtl/hsv_to_rgb_pipe.sv
// 4-stage valid/ready HSV-to-RGB converter with a global stall.
// Optional sideband pass-through is enabled with HSV2RGB_SIDEBAND_EN.
module hsv_to_rgb_pipe #(
    parameter int USER_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_h,
    input  logic [7:0]        in_s,
    input  logic [7:0]        in_v,
`ifdef HSV2RGB_SIDEBAND_EN
    input  logic [USER_W-1:0] in_user,
    output logic [USER_W-1:0] out_user,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_r,
    output logic [7:0]        out_g,
    output logic [7:0]        out_b
);

    import hsv_pkg::*;

    logic       adv;
    logic [3:0] vld;

    sector_t    s1_sec, s2_sec, s3_sec;
    chan_t      s1_f8, s1_s, s1_v, s2_s, s2_v, s3_v;
    logic [15:0] s2_ps, s2_pc, s3_vp, s3_vq, s3_vt;

    logic [8:0] h_w;
    sector_t    sec_c;
    logic [5:0] f_c;
    chan_t      f8_c;

    chan_t      d_ps, d_pc, mp, mq, mt;
    chan_t      p, q, t;
    chan_t      r_c, g_c, b_c;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[3];

    // S1: hue wrap and sector/fraction extraction
    always_comb begin
        h_w   = (in_h >= 9'(HUE_DEG_MAX)) ? in_h - 9'(HUE_DEG_MAX) : in_h;
        sec_c = hue_sector(h_w);
        f_c   = 6'(h_w - sector_base(sec_c));
        f8_c  = 8'(({4'd0, f_c} * 10'd17) >> 2);
    end

    hsv_div255 u_div_ps (.x(s2_ps), .y(d_ps));
    hsv_div255 u_div_pc (.x(s2_pc), .y(d_pc));

    assign mp = 8'd255 - s2_s;
    assign mq = 8'd255 - d_ps;
    assign mt = 8'd255 - d_pc;

    hsv_div255 u_div_p (.x(s3_vp), .y(p));
    hsv_div255 u_div_q (.x(s3_vq), .y(q));
    hsv_div255 u_div_t (.x(s3_vt), .y(t));

    always_comb begin
        r_c = s3_v;
        g_c = s3_v;
        b_c = s3_v;
        case (s3_sec)
            SEC_0: begin r_c = s3_v; g_c = t;    b_c = p;    end
            SEC_1: begin r_c = q;    g_c = s3_v; b_c = p;    end
            SEC_2: begin r_c = p;    g_c = s3_v; b_c = t;    end
            SEC_3: begin r_c = p;    g_c = q;    b_c = s3_v; end
            SEC_4: begin r_c = t;    g_c = p;    b_c = s3_v; end
            SEC_5: begin r_c = s3_v; g_c = p;    b_c = q;    end
            default: begin r_c = s3_v; g_c = s3_v; b_c = s3_v; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            s1_sec <= SEC_0;
            s1_f8  <= '0;
            s1_s   <= '0;
            s1_v   <= '0;
            s2_sec <= SEC_0;
            s2_ps  <= '0;
            s2_pc  <= '0;
            s2_s   <= '0;
            s2_v   <= '0;
            s3_sec <= SEC_0;
            s3_vp  <= '0;
            s3_vq  <= '0;
            s3_vt  <= '0;
            s3_v   <= '0;
            out_r  <= '0;
            out_g  <= '0;
            out_b  <= '0;
        end else if (adv) begin
            vld    <= {vld[2:0], in_valid};
            s1_sec <= sec_c;
            s1_f8  <= f8_c;
            s1_s   <= in_s;
            s1_v   <= in_v;
            s2_sec <= s1_sec;
            s2_ps  <= {8'd0, s1_s} * {8'd0, s1_f8};
            s2_pc  <= {8'd0, s1_s} * {8'd0, 8'd255 - s1_f8};
            s2_s   <= s1_s;
            s2_v   <= s1_v;
            s3_sec <= s2_sec;
            s3_vp  <= {8'd0, s2_v} * {8'd0, mp};
            s3_vq  <= {8'd0, s2_v} * {8'd0, mq};
            s3_vt  <= {8'd0, s2_v} * {8'd0, mt};
            s3_v   <= s2_v;
            out_r  <= r_c;
            out_g  <= g_c;
            out_b  <= b_c;
        end
    end

`ifdef HSV2RGB_SIDEBAND_EN
    logic [USER_W-1:0] u1, u2, u3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u1       <= '0;
            u2       <= '0;
            u3       <= '0;
            out_user <= '0;
        end else if (adv) begin
            u1       <= in_user;
            u2       <= u1;
            u3       <= u2;
            out_user <= u3;
        end
    end
`endif

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// Scoreboard bench for hsv_to_rgb_pipe: directed HSV vectors with hand-computed RGB results.
module tb_hsv_to_rgb_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_h;
    logic [7:0] in_s, in_v;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r, out_g, out_b;
`ifdef HSV2RGB_SIDEBAND_EN
    logic [1:0] in_user;
    logic [1:0] out_user;
`endif

    always #5 clk = ~clk;

    hsv_to_rgb_pipe #(.USER_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_h      (in_h),
        .in_s      (in_s),
        .in_v      (in_v),
`ifdef HSV2RGB_SIDEBAND_EN
        .in_user   (in_user),
        .out_user  (out_user),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic [1:0] u;
        int         edge_a;
        int         stalls_a;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         edge_cnt = 0;
    int         stall_cnt = 0;
    int         out_cnt = 0;
    int         tag = 0;
    logic [7:0] pend_r, pend_g, pend_b;
    logic [7:0] held_r, held_g, held_b;
    logic       prev_stall = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor + acceptance tracking share one process so stall counting is ordered with pops/pushes.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt++;
                check("stall_in_ready", int'(in_ready), 0);
                if (prev_stall) begin
                    check("stall_hold_r", int'(out_r), int'(held_r));
                    check("stall_hold_g", int'(out_g), int'(held_g));
                    check("stall_hold_b", int'(out_b), int'(held_b));
                end
                held_r = out_r; held_g = out_g; held_b = out_b;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_r", int'(out_r), int'(e.r));
                    check("out_g", int'(out_g), int'(e.g));
                    check("out_b", int'(out_b), int'(e.b));
                    check("latency_edge", edge_cnt, e.edge_a + 3 + (stall_cnt - e.stalls_a));
`ifdef HSV2RGB_SIDEBAND_EN
                    check("out_user", int'(out_user), int'(e.u));
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.r = pend_r; n.g = pend_g; n.b = pend_b;
`ifdef HSV2RGB_SIDEBAND_EN
                n.u = in_user;
`else
                n.u = 2'd0;
`endif
                n.edge_a   = edge_cnt + 1;
                n.stalls_a = stall_cnt;
                sb.push_back(n);
            end
        end
    end

    task automatic send(input logic [8:0] h, input logic [7:0] s, input logic [7:0] v,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int guard;
        in_h = h; in_s = s; in_v = v;
        pend_r = r; pend_g = g; pend_b = b;
`ifdef HSV2RGB_SIDEBAND_EN
        in_user = 2'(tag);
`endif
        tag++;
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int saved_cnt, saved_stall;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_h = '0; in_s = '0; in_v = '0;
        pend_r = '0; pend_g = '0; pend_b = '0;
`ifdef HSV2RGB_SIDEBAND_EN
        in_user = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_rgb", int'({out_r, out_g, out_b}), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef HSV2RGB_SIDEBAND_EN
        check("rst_out_user", int'(out_user), 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // isolated pixels with bubbles between them
        send(9'd0,   8'd255, 8'd255, 8'd255, 8'd0,   8'd0);
        idle(6);
        send(9'd120, 8'd255, 8'd255, 8'd0,   8'd255, 8'd0);
        idle(6);
        send(9'd240, 8'd255, 8'd255, 8'd0,   8'd0,   8'd255);
        idle(6);

        // back-to-back stream
        send(9'd30,  8'd255, 8'd255, 8'd255, 8'd127, 8'd0);
        send(9'd420, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0);
        send(9'd0,   8'd0,   8'd128, 8'd128, 8'd128, 8'd128);
        send(9'd200, 8'd0,   8'd128, 8'd128, 8'd128, 8'd128);
        send(9'd359, 8'd0,   8'd128, 8'd128, 8'd128, 8'd128);
        send(9'd359, 8'd255, 8'd255, 8'd255, 8'd0,   8'd5);
        send(9'd511, 8'd255, 8'd255, 8'd0,   8'd255, 8'd131);
        send(9'd360, 8'd255, 8'd255, 8'd255, 8'd0,   8'd0);
        send(9'd0,   8'd255, 8'd100, 8'd100, 8'd0,   8'd0);
        idle(8);
        check("drain1_empty", sb.size(), 0);
        check("drain1_count", out_cnt, 12);

        // backpressure: 8 distinct pixels, 3-cycle stall mid-stream
        saved_stall = stall_cnt;
        fork
            begin
                send(9'd0,   8'd255, 8'd255, 8'd255, 8'd0,   8'd0);
                send(9'd60,  8'd255, 8'd255, 8'd255, 8'd255, 8'd0);
                send(9'd120, 8'd255, 8'd255, 8'd0,   8'd255, 8'd0);
                send(9'd180, 8'd255, 8'd255, 8'd0,   8'd255, 8'd255);
                send(9'd240, 8'd255, 8'd255, 8'd0,   8'd0,   8'd255);
                send(9'd300, 8'd255, 8'd255, 8'd255, 8'd0,   8'd255);
                send(9'd30,  8'd255, 8'd255, 8'd255, 8'd127, 8'd0);
                send(9'd200, 8'd0,   8'd128, 8'd128, 8'd128, 8'd128);
            end
            begin
                idle(5);
                out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(10);
        check("stall_cycles", stall_cnt - saved_stall, 3);
        check("drain2_empty", sb.size(), 0);
        check("drain2_count", out_cnt, 20);

        // reset with the pipeline full: one pixel at the output, three behind it
        send(9'd0,   8'd255, 8'd255, 8'd255, 8'd0,   8'd0);
        send(9'd120, 8'd255, 8'd255, 8'd0,   8'd255, 8'd0);
        send(9'd240, 8'd255, 8'd255, 8'd0,   8'd0,   8'd255);
        send(9'd60,  8'd255, 8'd255, 8'd255, 8'd255, 8'd0);
        check("pre_reset_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_rgb", int'({out_r, out_g, out_b}), 0);
        sb.delete();
        saved_cnt = out_cnt;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(9'd200, 8'd0,   8'd128, 8'd128, 8'd128, 8'd128);
        idle(8);
        check("post_reset_count", out_cnt - saved_cnt, 1);
        check("post_reset_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
